// File: rtl/button_pkg.sv
// Shared types and default timing for the button event classifier.
// Event codes, classifier states and a helper for sizing the cycle counter.
package button_pkg;

  typedef enum logic [1:0] {
    EVT_REPEAT = 2'b00,
    EVT_SHORT  = 2'b01,
    EVT_LONG   = 2'b10,
    EVT_DOUBLE = 2'b11
  } evt_code_t;

  typedef enum logic [2:0] {
    IDLE,
    PRESSED1,
    WAIT2,
    PRESSED2,
    LONG_HELD
  } state_t;

  // Default timings at the 3 MHz system clock.
  localparam int unsigned DEF_LONG_PRESS_CYCLES   = 3000000;
  localparam int unsigned DEF_DOUBLE_CLICK_CYCLES = 900000;
  localparam int unsigned DEF_REPEAT_CYCLES       = 600000;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/button_event_classifier_if.sv
// Event delivery channel: valid/ready handshake carrying a 2-bit event code,
// plus the drop pulse raised when an event is lost to a full buffer.
interface button_event_classifier_if;
  import button_pkg::*;

  logic      evt_valid;
  evt_code_t evt_code;
  logic      evt_ready;
  logic      evt_drop;

  modport master (output evt_valid, output evt_code, output evt_drop, input evt_ready);
  modport slave  (input evt_valid, input evt_code, input evt_drop, output evt_ready);
endinterface

// File: rtl/button_event_classifier_event_slot.sv
// One-entry valid/ready output buffer. A new event arriving while the held
// event is still unaccepted is discarded and reported on evt_drop.
module event_slot
  import button_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      new_valid,
  input  evt_code_t new_code,
  button_event_classifier_if.master evt
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt.evt_valid <= 1'b0;
      evt.evt_code  <= EVT_REPEAT;
      evt.evt_drop  <= 1'b0;
    end else begin
      evt.evt_drop <= 1'b0;
      if (new_valid) begin
        // An accept in the same cycle frees the slot for the new event.
        if (!evt.evt_valid || evt.evt_ready) begin
          evt.evt_valid <= 1'b1;
          evt.evt_code  <= new_code;
        end else begin
          evt.evt_drop <= 1'b1;
        end
      end else if (evt.evt_ready) begin
        evt.evt_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/button_event_classifier.sv
// Classifies debounced press/release pulses into SHORT, LONG and DOUBLE events.
// Define BTN_AUTOREPEAT_EN to emit periodic REPEAT events while a long press is held.
module button_event_classifier
  import button_pkg::*;
#(
  parameter int unsigned LONG_PRESS_CYCLES   = DEF_LONG_PRESS_CYCLES,
  parameter int unsigned DOUBLE_CLICK_CYCLES = DEF_DOUBLE_CLICK_CYCLES,
  parameter int unsigned REPEAT_CYCLES       = DEF_REPEAT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic press_pulse,
  input  logic release_pulse,
  button_event_classifier_if.master evt
);

  localparam int unsigned CNT_W =
    $clog2(max3(LONG_PRESS_CYCLES, DOUBLE_CLICK_CYCLES, REPEAT_CYCLES)) + 1;
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] DC_LAST   = CNT_W'(DOUBLE_CLICK_CYCLES - 1);
`ifdef BTN_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
`endif

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             press_eff;
  logic             emit_valid;
  evt_code_t        emit_code;

  // A press coinciding with a release is ignored; the release is processed.
  assign press_eff = press_pulse & ~release_pulse;

  // Event decision is combinational so the slot registers it one cycle
  // after the deciding pulse or timeout.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    emit_valid = 1'b0;
    emit_code  = EVT_REPEAT;
    case (state)
      PRESSED1: if (!release_pulse && cnt == LONG_LAST) begin
        emit_valid = 1'b1;
        emit_code  = EVT_LONG;
      end
      WAIT2: if (!press_eff && cnt == DC_LAST) begin
        emit_valid = 1'b1;
        emit_code  = EVT_SHORT;
      end
      PRESSED2: if (release_pulse) begin
        emit_valid = 1'b1;
        emit_code  = EVT_DOUBLE;
      end
`ifdef BTN_AUTOREPEAT_EN
      LONG_HELD: if (!release_pulse && cnt == REP_LAST) begin
        emit_valid = 1'b1;
        emit_code  = EVT_REPEAT;
      end
`endif
      default: ;
    endcase
  end

  // NOTE: asynchronous active-low reset aborts any gesture in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (press_eff) begin
          state <= PRESSED1;
          cnt   <= '0;
        end
        PRESSED1: begin
          if (release_pulse) begin
            state <= WAIT2;
            cnt   <= '0;
          end else if (cnt == LONG_LAST) begin
            state <= LONG_HELD;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT2: begin
          // A second press on the final gap cycle still counts as a double click.
          if (press_eff) begin
            state <= PRESSED2;
            cnt   <= '0;
          end else if (cnt == DC_LAST) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PRESSED2: if (release_pulse) begin
          state <= IDLE;
          cnt   <= '0;
        end
        LONG_HELD: begin
          if (release_pulse) begin
            state <= IDLE;
            cnt   <= '0;
          end
`ifdef BTN_AUTOREPEAT_EN
          else if (cnt == REP_LAST) begin
            cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  event_slot u_slot (
    .clk       (clk),
    .rst_n     (rst_n),
    .new_valid (emit_valid),
    .new_code  (emit_code),
    .evt       (evt)
  );

endmodule

// File: tb/tb_button_event_classifier.sv
// Scoreboard bench for button_event_classifier with LONG=20, DC=8, REPEAT=5.
// Cycle 0 is the cycle in which reset is released; inputs driven in cycle t.
module tb_button_event_classifier;
  import button_pkg::*;

  localparam int LP = 20;
  localparam int DC = 8;
  localparam int RP = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic press = 1'b0;
  logic rel = 1'b0;

  button_event_classifier_if evt ();

  button_event_classifier #(
    .LONG_PRESS_CYCLES   (LP),
    .DOUBLE_CLICK_CYCLES (DC),
    .REPEAT_CYCLES       (RP)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .press_pulse   (press),
    .release_pulse (rel),
    .evt           (evt)
  );

  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  typedef struct {
    evt_code_t code;
    int        at;
  } exp_t;

  exp_t evt_q[$];
  int   drop_q[$];
  int   total = 0;
  int   bad = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every handshake and every drop pulse must match the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    int   d;
    if (rst_n) begin
      if (evt.evt_valid && evt.evt_ready) begin
        if (evt_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_evt: got code %0d at cycle %0d, none expected",
                   evt.evt_code, cyc);
        end else begin
          e = evt_q.pop_front();
          check("evt_code", int'(evt.evt_code), int'(e.code));
          check("evt_cycle", cyc, e.at);
        end
      end
      if (evt.evt_drop) begin
        if (drop_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_drop: got drop at cycle %0d, none expected", cyc);
        end else begin
          d = drop_q.pop_front();
          check("drop_cycle", cyc, d);
        end
      end
    end
  end

  task automatic go_to(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press_at(input int t);
    go_to(t);
    press = 1'b1;
    go_to(t + 1);
    press = 1'b0;
  endtask

  task automatic rel_at(input int t);
    go_to(t);
    rel = 1'b1;
    go_to(t + 1);
    rel = 1'b0;
  endtask

  task automatic push_evt(input evt_code_t c, input int t);
    exp_t e;
    e.code = c;
    e.at   = t;
    evt_q.push_back(e);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    press = 1'b0;
    rel   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic finish_test(input int t);
    go_to(t);
    check("pending_evt", evt_q.size(), 0);
    check("pending_drop", drop_q.size(), 0);
  endtask

  initial begin
    evt.evt_ready = 1'b1;

    // Reset state
    @(posedge clk);
    #1;
    check("rst_valid", int'(evt.evt_valid), 0);
    check("rst_code", int'(evt.evt_code), 0);
    check("rst_drop", int'(evt.evt_drop), 0);

    // SHORT: press 10, release 14 -> valid at 23 for exactly one cycle
    do_reset();
    push_evt(EVT_SHORT, 23);
    press_at(10);
    rel_at(14);
    finish_test(40);

    // LONG: press 10 held -> LONG at 31; release at 40
    do_reset();
    push_evt(EVT_LONG, 31);
`ifdef BTN_AUTOREPEAT_EN
    push_evt(EVT_REPEAT, 36);
`endif
    press_at(10);
    rel_at(40);
    finish_test(70);

    // DOUBLE: press 10, release 13, press 17, release 19 -> DOUBLE at 20
    do_reset();
    push_evt(EVT_DOUBLE, 20);
    press_at(10);
    rel_at(13);
    press_at(17);
    rel_at(19);
    finish_test(45);

    // Second press on the last gap cycle (r+8) wins over the timeout
    do_reset();
    push_evt(EVT_DOUBLE, 25);
    press_at(10);
    rel_at(13);
    press_at(21);
    rel_at(24);
    finish_test(50);

    // Sustained hold: repeats only with the autorepeat build
    do_reset();
    push_evt(EVT_LONG, 31);
`ifdef BTN_AUTOREPEAT_EN
    push_evt(EVT_REPEAT, 36);
    push_evt(EVT_REPEAT, 41);
    push_evt(EVT_REPEAT, 46);
`endif
    press_at(10);
    rel_at(48);
    finish_test(70);

    // Back-pressure: SHORT held, LONG dropped, third event loads on accept
    do_reset();
    evt.evt_ready = 1'b0;
    push_evt(EVT_SHORT, 76);
    push_evt(EVT_DOUBLE, 77);
    drop_q.push_back(51);
`ifdef BTN_AUTOREPEAT_EN
    drop_q.push_back(56);
`endif
    press_at(10);
    rel_at(14);
    press_at(30);
    go_to(45);
    check("held_valid", int'(evt.evt_valid), 1);
    check("held_code", int'(evt.evt_code), int'(EVT_SHORT));
    rel_at(59);
    press_at(70);
    rel_at(72);
    press_at(74);
    go_to(76);
    evt.evt_ready = 1'b1;
    rel = 1'b1;
    go_to(77);
    rel = 1'b0;
    finish_test(100);

    // Reset mid-gesture clears the buffered event and emits nothing after
    do_reset();
    evt.evt_ready = 1'b0;
    press_at(2);
    rel_at(4);
    press_at(15);
    go_to(20);
    check("pre_rst_valid", int'(evt.evt_valid), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", int'(evt.evt_valid), 0);
    check("mid_rst_code", int'(evt.evt_code), 0);
    check("mid_rst_drop", int'(evt.evt_drop), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    evt.evt_ready = 1'b1;
    finish_test(60);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule

// File: doc/button_event_classifier.md
Name: button_event_classifier

Overview:
Sits directly downstream of the button debouncer and consumes its single-cycle btn_pressed/btn_released pulses. Classifies each gesture as SHORT, LONG or DOUBLE (click) using cycle-count timers at the 3 MHz system clock. Delivers one event code per gesture through a one-entry valid/ready buffer to the control logic.

Parameters:
LONG_PRESS_CYCLES, 3000000, hold time that qualifies as a long press (1 s @ 3 MHz)
DOUBLE_CLICK_CYCLES, 900000, maximum release-to-second-press gap for a double click (300 ms)
REPEAT_CYCLES, 600000, auto-repeat period while long-held (200 ms); used only with the optional feature

Ports:
clk  in  1  system clock, 3 MHz
rst_n  in  1  asynchronous active-low reset
press_pulse  in  1  single-cycle pulse, debounced press
release_pulse  in  1  single-cycle pulse, debounced release
evt_valid  out  1  event available
evt_code  out  2  00 REPEAT, 01 SHORT, 10 LONG, 11 DOUBLE
evt_ready  in  1  consumer accepts the event when evt_valid && evt_ready
evt_drop  out  1  single-cycle pulse: event lost because the buffer was full

Behaviour:
- Reset: state IDLE, counter 0, evt_valid 0, evt_code 00, evt_drop 0.
- Counter width: $clog2 of the largest parameter, plus 1. Counter is cleared on every state entry.
- Timing convention: a pulse at cycle t changes the state at t+1.
- IDLE:
  - press -> PRESSED1.
  - release ignored.
- PRESSED1:
  - release -> WAIT2.
  - No release and cnt == LONG_PRESS_CYCLES-1 -> emit LONG, go to LONG_HELD.
  - Otherwise cnt++.
- WAIT2:
  - press -> PRESSED2. This includes the cycle where cnt == DOUBLE_CLICK_CYCLES-1: press wins over timeout.
  - cnt == DOUBLE_CLICK_CYCLES-1 with no press -> emit SHORT, go to IDLE.
  - Otherwise cnt++.
- PRESSED2:
  - release -> emit DOUBLE, go to IDLE.
  - No timeout in this state.
- LONG_HELD:
  - release -> IDLE, no event.
- press and release in the same cycle: press ignored, release processed.
- Latency: evt_valid rises the cycle after the deciding pulse or timeout.
  - LONG: press at t -> evt_valid at t+LONG_PRESS_CYCLES+1.
  - SHORT: release at r -> evt_valid at r+DOUBLE_CLICK_CYCLES+1.
- Output buffer (one entry):
  - evt_valid/evt_code are held stable until accepted.
  - On accept with no new event: evt_valid drops next cycle.
  - New event while evt_valid && !evt_ready: new event discarded, old event kept, evt_drop pulses one cycle.
  - New event in the same cycle as an accept: new event loads and evt_valid stays high; no drop.
- Reset mid-gesture aborts the gesture; no event is emitted.

Optional Feature:
Macro BTN_AUTOREPEAT_EN.
- Defined: in LONG_HELD a repeat counter runs. Each time it reaches REPEAT_CYCLES-1, emit REPEAT (00) and restart the counter. The first REPEAT comes REPEAT_CYCLES after the LONG event. REPEAT events are subject to the normal buffer and drop rules.
- Undefined: LONG_HELD only waits for release. Code 00 is never produced and REPEAT_CYCLES is unused.

Decomposition:
- Shared package button_pkg holds:
  - evt_code_t enum (EVT_REPEAT, EVT_SHORT, EVT_LONG, EVT_DOUBLE);
  - classifier state_t enum (IDLE, PRESSED1, WAIT2, PRESSED2, LONG_HELD);
  - default timing constants.
- One sub-module, event_slot: the one-entry valid/ready buffer with drop detection. The FSM plus counter remains in the top module.

Test Plan (LONG=20, DC=8, REPEAT=5, evt_ready=1 unless noted):
- Press at t=10, release at t=14 -> SHORT (01), evt_valid high exactly at t=23 for one cycle.
- Press at t=10, no release -> LONG (10) at t=31. Release at t=40 -> no further event.
- Press t=10, release t=13, press t=17, release t=19 -> DOUBLE (11) at t=20. No SHORT is ever emitted.
- Second press in the same cycle the gap timer expires (press at r+8) -> DOUBLE on the following release, no SHORT.
- evt_ready=0, produce SHORT then LONG -> SHORT held, evt_drop pulses once when LONG is decided. Raise evt_ready in the cycle a third event is decided -> the third event loads, evt_drop stays 0.
- With BTN_AUTOREPEAT_EN: hold from t=10 -> LONG at t=31, REPEAT (00) at t=36, 41, 46. Without the macro -> LONG only. rst_n low at t=20 of any run -> all outputs 0, no event.
